// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one synchronous single-port memory between the CPU controller
// (cpu_*) and an external loader/debug port (ext_*). Each access runs
// IDLE -> ISSUE -> RESP. The CPU has fixed priority, but a starvation
// counter lets the external port win once it has lost MAX_WAIT
// consecutive contested arbitrations.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i  CPU request (held stable until grant)
//   cpu_gnt_o                      1-cycle pulse, CPU access on memory bus
//   cpu_rvalid_o, cpu_rdata_o      CPU read result pulse / held read data
//   ext_*                          same set for the external port
//   mem_en_o/we_o/addr_o/wdata_o   memory command (sampled by memory)
//   mem_rdata_i                    memory read data, valid cycle after issue
//   busy_o                         arbiter is not in IDLE
module mem_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_o,
  output logic              ext_rvalid_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic       OWNER_CPU  = 1'b0;
  localparam logic       OWNER_EXT  = 1'b1;

  state_e              state_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          wait_cnt_q;
  logic                cpu_gnt_q;
  logic                ext_gnt_q;
  logic                cpu_rvalid_q;
  logic                ext_rvalid_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   ext_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic                busy_q;
  logic                ext_win_s;

  // Winner selection: ext takes the slot when the CPU is absent or has
  // starved it for MAX_WAIT contested rounds.
  always_comb begin
    ext_win_s = 1'b0;
    if (ext_req_i && (!cpu_req_i || (wait_cnt_q == MAX_WAIT_C))) begin
      ext_win_s = 1'b1;
    end else begin
      ext_win_s = 1'b0;
    end
  end

  // Arbitration FSM with request register, starvation counter and all
  // registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      owner_q      <= OWNER_CPU;
      we_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      wait_cnt_q   <= 4'd0;
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rdata_q  <= {DATA_W{1'b0}};
      ext_rdata_q  <= {DATA_W{1'b0}};
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Pulses default low so every gnt/rvalid lasts exactly one cycle.
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;

      // Starvation history is meaningless once ext stops asking.
      if (!ext_req_i) begin
        wait_cnt_q <= 4'd0;
      end

      case (state_q)
        S_IDLE: begin
          if (cpu_req_i || ext_req_i) begin
            state_q  <= S_ISSUE;
            busy_q   <= 1'b1;
            mem_en_q <= 1'b1;
            if (ext_win_s) begin
              owner_q    <= OWNER_EXT;
              we_q       <= ext_we_i;
              addr_q     <= ext_addr_i;
              wdata_q    <= ext_wdata_i;
              mem_we_q   <= ext_we_i;
              ext_gnt_q  <= 1'b1;
              wait_cnt_q <= 4'd0;
            end else begin
              owner_q   <= OWNER_CPU;
              we_q      <= cpu_we_i;
              addr_q    <= cpu_addr_i;
              wdata_q   <= cpu_wdata_i;
              mem_we_q  <= cpu_we_i;
              cpu_gnt_q <= 1'b1;
              if (ext_req_i && (wait_cnt_q < MAX_WAIT_C)) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
              end
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_ISSUE: begin
          state_q <= S_RESP;
          busy_q  <= 1'b1;
        end
        S_RESP: begin
          // mem_rdata_i is valid this cycle for a read issued last cycle.
          if (!we_q) begin
            if (owner_q == OWNER_EXT) begin
              ext_rdata_q  <= mem_rdata_i;
              ext_rvalid_q <= 1'b1;
            end else begin
              cpu_rdata_q  <= mem_rdata_i;
              cpu_rvalid_q <= 1'b1;
            end
          end
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Reset gates the memory strobes immediately so an ISSUE cycle that
  // coincides with reset cannot commit a write.
  assign mem_en_o     = mem_en_q & ~rst_i;
  assign mem_we_o     = mem_we_q & ~rst_i;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign cpu_gnt_o    = cpu_gnt_q;
  assign ext_gnt_o    = ext_gnt_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign ext_rvalid_o = ext_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign ext_rdata_o  = ext_rdata_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single-port data/instruction memory of the multi-cycle CPU. Shares the memory between the CPU controller's fetch/operand path (`cpu_*`) and an external loader/debug port (`ext_*`). It serialises accesses through a three-state FSM: fixed CPU priority, plus a starvation counter that guarantees the external port a slot. Memory is synchronous: address, enable and write are sampled at a clock edge, and read data is valid in the following cycle.

## Interface
- ADDR_W, 5, memory address width
- DATA_W, 8, memory data width
- MAX_WAIT, 4, consecutive lost arbitrations after which `ext` wins (1..15)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- cpu_req  in  1  CPU access request; hold with stable addr/we/wdata until `cpu_gnt`
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU access issued to memory this cycle
- cpu_rvalid  out  1  one-cycle pulse: `cpu_rdata` updated with read result
- cpu_rdata  out  DATA_W  last CPU read data, held until next CPU read completes
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  same meaning for external port
- ext_gnt, ext_rvalid  out  1  same meaning for external port
- ext_rdata  out  DATA_W  same meaning for external port
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable (only with `mem_en`)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read issue
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: requests are sampled only here.
  - If no request is present, remain in IDLE.
  - Otherwise pick an owner, latch its we/addr/wdata into the request register, and go to ISSUE.
- Winner selection:
  - `ext` wins if `ext_req` and (`!cpu_req` or `wait_cnt == MAX_WAIT`).
  - Otherwise `cpu` wins.
- wait_cnt (4 bit):
  - Increments in IDLE when `ext_req && cpu_req` and `cpu` wins.
  - Clears when `ext` is granted or `ext_req` = 0.
  - Never exceeds MAX_WAIT.
- ISSUE:
  - `mem_en` = 1 and `mem_we` = latched we; `mem_addr`/`mem_wdata` come from the request register.
  - The owner's gnt = 1.
  - Go to RESP.
- RESP:
  - `mem_en` = 0.
  - If the latched access is a read, capture `mem_rdata` into the owner's rdata register at the end of this cycle and set the owner's rvalid for the next cycle.
  - Go to IDLE.
- Writes commit at the edge ending ISSUE; no rvalid is produced for writes.
- Requester rule: drop req in the cycle after gnt at the latest. A req still high when IDLE is re-entered is taken as a new access.
- The other owner's rdata/rvalid are never disturbed.
- `mem_en`/`mem_we` are combinationally forced to 0 while `rst` = 1, so an ISSUE write coinciding with reset is suppressed.

## Timing
- Reset values:
  - State IDLE, wait_cnt 0.
  - All gnt/rvalid 0; cpu_rdata/ext_rdata 0.
  - mem_en/mem_we 0; mem_addr/mem_wdata 0 (request register cleared).
  - busy 0.
- Access latency: req high at edge e0 in IDLE → gnt and mem_en in cycle e0..e1 → mem_rdata valid e1..e2 → rdata/rvalid visible e2..e3. Read latency is 3 cycles from the sampling edge.
- Throughput: one access per 3 cycles; back-to-back accesses have IDLE in between.
- gnt and rvalid are exactly one cycle wide.
- Reset mid-operation: the access is abandoned, with no gnt/rvalid afterwards. A request still asserted after reset is re-arbitrated from IDLE.
- Simultaneous cpu_req and ext_req with wait_cnt < MAX_WAIT: CPU wins; ext wins the first IDLE where wait_cnt == MAX_WAIT.
- Changing addr/we/wdata after the IDLE sample has no effect on the issued access.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, busy 0, mem_en never high.
- CPU write addr 5'h03 data 8'hA5, then CPU read addr 5'h03 → write: cpu_gnt pulse, no cpu_rvalid. Read: cpu_rvalid pulse 3 cycles after the sample edge, cpu_rdata = 8'hA5.
- ext read addr 5'h1F (memory preloaded 8'h3C) while CPU idle → ext_gnt, then ext_rvalid with ext_rdata = 8'h3C; cpu_rdata unchanged.
- cpu_req and ext_req held high continuously, MAX_WAIT = 4 → grant sequence cpu,cpu,cpu,cpu,ext repeating; wait_cnt never exceeds 4.
- Assert rst during ISSUE of an ext write of 8'hFF to 5'h07 → mem_we low that cycle; location 5'h07 keeps its old value; no ext_rvalid; FSM IDLE after reset.
- Simultaneous first request from both ports after reset → cpu_gnt first; ext_gnt follows 3 cycles later if cpu_req drops.
